// File: rtl/led_frame_transmitter.sv
// led_frame_transmitter: serialises a frame of 24-bit GRB pixels onto a WS2812-style one-wire chain.
// Define LED_FRAME_TRANSMITTER_REPEAT_EN to add repeat_i for continuous refresh without start_i.
module led_frame_transmitter #(
  parameter int LED_COUNT    = 150,
  parameter int BIT_CYCLES   = 15,
  parameter int T0H_CYCLES   = 4,
  parameter int T1H_CYCLES   = 9,
  parameter int RESET_CYCLES = 600
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic        start_i,
`ifdef LED_FRAME_TRANSMITTER_REPEAT_EN
  input  logic        repeat_i,
`endif
  input  logic [23:0] pixel_data_i,
  output logic [7:0]  led_index_o,
  output logic        data_out_o,
  output logic        busy_o,
  output logic        frame_done_o
);
  localparam int PW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int LW = (RESET_CYCLES > 0) ? $clog2(RESET_CYCLES + 1) : 1;
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] LATCH = 3'd4;
  localparam logic [7:0] IDX_TOP = 8'(LED_COUNT - 1);
  localparam logic [7:0] IDX_NEXT = (LED_COUNT > 1) ? 8'(LED_COUNT - 2) : 8'd0;
  localparam logic [PW-1:0] PH_LAST = PW'(BIT_CYCLES - 1);
  localparam logic [PW-1:0] T0H = PW'(T0H_CYCLES);
  localparam logic [PW-1:0] T1H = PW'(T1H_CYCLES);
  localparam logic [LW-1:0] L_LAST = LW'(RESET_CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic [7:0]    idx_q, idx_d;
  logic [23:0]   shift_q, shift_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [LW-1:0] latch_q, latch_d;
  logic          last_q, last_d;
  logic          rep;

`ifdef LED_FRAME_TRANSMITTER_REPEAT_EN
  assign rep = repeat_i;
`else
  assign rep = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    latch_d = latch_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        idx_d   = IDX_TOP;
        state_d = start_i ? FETCH : IDLE;
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        shift_d = pixel_data_i;
        idx_d   = IDX_NEXT;
        last_d  = (LED_COUNT == 1);
        phase_d = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          if (cnt_q == 5'd23) begin
            cnt_d = '0;
            if (last_q) begin
              state_d = LATCH;
              latch_d = '0;
            end else begin
              // idx_q already points at the LED being loaded, so memory data is ready
              shift_d = pixel_data_i;
              last_d  = (idx_q == 8'd0);
              idx_d   = (idx_q == 8'd0) ? 8'd0 : idx_q - 8'd1;
            end
          end else begin
            cnt_d   = cnt_q + 5'd1;
            shift_d = {shift_q[22:0], 1'b0};
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      LATCH: begin
        if (latch_q == L_LAST) begin
          idx_d   = IDX_TOP;
          state_d = rep ? FETCH : IDLE;
        end else begin
          latch_d = latch_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      idx_q   <= IDX_TOP;
      shift_q <= '0;
      phase_q <= '0;
      cnt_q   <= '0;
      latch_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
      last_q  <= last_d;
    end
  end

  assign led_index_o  = idx_q;
  assign busy_o       = (state_q != IDLE);
  assign data_out_o   = (state_q == SHIFT) && (phase_q < (shift_q[23] ? T1H : T0H));
  assign frame_done_o = (state_q == LATCH) && (latch_q == L_LAST);
endmodule

// File: tb/tb_led_frame_transmitter.sv
// tb_led_frame_transmitter: scoreboard bench decoding pulse widths, frame_done timing and index sequencing.
module tb_led_frame_transmitter;
  logic        clock_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        start_i = 1'b0;
`ifdef LED_FRAME_TRANSMITTER_REPEAT_EN
  logic        repeat_i = 1'b0;
`endif
  logic [23:0] pixel_data_i = 24'd0;
  logic [7:0]  led_index_o;
  logic        data_out_o, busy_o, frame_done_o;

  led_frame_transmitter #(.LED_COUNT(3), .BIT_CYCLES(15), .T0H_CYCLES(4), .T1H_CYCLES(9),
                          .RESET_CYCLES(600)) dut (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .start_i(start_i),
`ifdef LED_FRAME_TRANSMITTER_REPEAT_EN
    .repeat_i(repeat_i),
`endif
    .pixel_data_i(pixel_data_i), .led_index_o(led_index_o), .data_out_o(data_out_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o));

  always #5 clock_i = ~clock_i;

  logic [23:0] mem [0:3];
  always @(posedge clock_i) pixel_data_i <= mem[led_index_o[1:0]];

  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  int checks = 0, errors = 0, done_cnt = 0;
  bit mon_en = 1'b0;
  bit exp_bits[$];
  int exp_done[$];
  int exp_idx_cyc[$];
  int exp_idx_val[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Expected response of one frame whose start is driven on the negedge where cyc==k
  task automatic push_frame(input int k);
    for (int l = 2; l >= 0; l--) begin
      logic [23:0] px;
      px = mem[l];
      for (int b = 23; b >= 0; b--) exp_bits.push_back(px[b]);
    end
    exp_done.push_back(k + 1682);
    exp_idx_cyc.push_back(k + 3);    exp_idx_val.push_back(1);
    exp_idx_cyc.push_back(k + 363);  exp_idx_val.push_back(0);
    exp_idx_cyc.push_back(k + 1683); exp_idx_val.push_back(2);
  endtask

  initial begin
    bit prev_d = 1'b0, rise_ok = 1'b0;
    int hi = 0, last_rise = 0, ec;
    logic [7:0] prev_idx = 8'd2;
    forever begin
      @(negedge clock_i);
      if (!mon_en || !reset_n_i) begin
        prev_d = 1'b0; hi = 0; rise_ok = 1'b0; prev_idx = led_index_o;
      end else begin
        if (data_out_o) begin
          if (!prev_d) begin
            if (rise_ok) check("bit_period", cyc - last_rise, 15);
            last_rise = cyc;
            rise_ok = 1'b1;
          end
          hi++;
        end else if (prev_d) begin
          if (exp_bits.size() == 0) fail_now("unexpected_pulse");
          else check("bit_high", hi, exp_bits.pop_front() ? 9 : 4);
          hi = 0;
        end
        prev_d = data_out_o;
        if (frame_done_o) begin
          done_cnt++;
          rise_ok = 1'b0;
          if (exp_done.size() == 0) fail_now("unexpected_frame_done");
          else check("frame_done_cycle", cyc, exp_done.pop_front());
        end
        if (led_index_o != prev_idx) begin
          if (exp_idx_cyc.size() == 0) fail_now("unexpected_index_change");
          else begin
            ec = exp_idx_cyc.pop_front();
            check("index_change_cycle", cyc, ec);
            check("index_value", int'(led_index_o), exp_idx_val.pop_front());
          end
          prev_idx = led_index_o;
        end
      end
    end
  end

  task automatic pulse_start(output int k);
    @(negedge clock_i);
    k = cyc;
    start_i = 1'b1;
    @(negedge clock_i);
    start_i = 1'b0;
  endtask

  task automatic start_frame();
    int k;
    @(negedge clock_i);
    k = cyc;
    push_frame(k);
    start_i = 1'b1;
    @(negedge clock_i);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit found = 1'b0;
    for (int n = 0; n < 3000 && !found; n++) begin
      @(negedge clock_i);
      #1;
      found = frame_done_o;
    end
    if (!found) fail_now({name, "_timeout"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, seen;
    mem[0] = 24'hA5A5A5; mem[1] = 24'h000000; mem[2] = 24'hFF0000; mem[3] = 24'h000000;
    repeat (3) @(negedge clock_i);
    reset_n_i = 1'b1;
    @(negedge clock_i); #1;
    check("reset_led_index", int'(led_index_o), 2);
    check("reset_busy", int'(busy_o), 0);
    check("reset_data_out", int'(data_out_o), 0);
    check("reset_frame_done", int'(frame_done_o), 0);
    seen = 0;
    repeat (20) begin
      @(negedge clock_i); #1;
      seen += int'(data_out_o) + int'(busy_o);
    end
    check("idle_quiet", seen, 0);
    // Reset asserted while data_out is high mid-frame
    pulse_start(k);
    seen = 0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clock_i); #1;
      seen = int'(data_out_o);
    end
    check("pre_reset_high", seen, 1);
    #2 reset_n_i = 1'b0;
    #1;
    check("async_reset_data_out", int'(data_out_o), 0);
    check("async_reset_busy", int'(busy_o), 0);
    check("async_reset_index", int'(led_index_o), 2);
    @(negedge clock_i);
    reset_n_i = 1'b1;
    repeat (2) @(negedge clock_i);
    #1 check("post_reset_idle", int'(busy_o) + int'(data_out_o), 0);
    mon_en = 1'b1;

    // Single frame with distinct bit patterns per LED
    start_frame();
    wait_done("single_frame");
    @(negedge clock_i); #1;
    check("busy_after_done", int'(busy_o), 0);
    check("index_after_done", int'(led_index_o), 2);

    // start pulses while busy must be ignored
    mem[0] = 24'h800001; mem[1] = 24'h0F0F0F; mem[2] = 24'h123456;
    seen = done_cnt;
    start_frame();
    repeat (100) @(negedge clock_i);
    start_i = 1'b1;
    @(negedge clock_i) start_i = 1'b0;
    repeat (1250) @(negedge clock_i);
    #1 check("busy_in_latch", int'(busy_o), 1);
    start_i = 1'b1;
    @(negedge clock_i) start_i = 1'b0;
    wait_done("ignored_start_frame");
    repeat (1800) @(negedge clock_i);
    check("single_done_only", done_cnt - seen, 1);
    #1 check("busy_idle_after_ignore", int'(busy_o), 0);

    // start held high retriggers after one IDLE cycle
    @(negedge clock_i);
    k = cyc;
    push_frame(k);
    push_frame(k + 1683);
    start_i = 1'b1;
    wait_done("held_first");
    @(negedge clock_i); #1;
    check("held_idle_gap_busy", int'(busy_o), 0);
    @(negedge clock_i); #1;
    check("held_refetch_busy", int'(busy_o), 1);
    start_i = 1'b0;
    wait_done("held_second");
    @(negedge clock_i); #1;
    check("held_end_busy", int'(busy_o), 0);

`ifdef LED_FRAME_TRANSMITTER_REPEAT_EN
    repeat (5) @(negedge clock_i);
    @(negedge clock_i);
    k = cyc;
    push_frame(k);
    push_frame(k + 1682);
    push_frame(k + 3364);
    repeat_i = 1'b1;
    start_i = 1'b1;
    @(negedge clock_i) start_i = 1'b0;
    wait_done("repeat_first");
    @(negedge clock_i); #1;
    check("repeat_busy_1", int'(busy_o), 1);
    wait_done("repeat_second");
    @(negedge clock_i); #1;
    check("repeat_busy_2", int'(busy_o), 1);
    repeat_i = 1'b0;
    wait_done("repeat_third");
    @(negedge clock_i); #1;
    check("repeat_end_busy", int'(busy_o), 0);
`endif

    repeat (20) @(negedge clock_i);
    check("pending_bits", exp_bits.size(), 0);
    check("pending_done", exp_done.size(), 0);
    check("pending_index", exp_idx_cyc.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
